// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock, NK-parametrised key schedule.
// Valid/ready on both sides; the result is held in data_out until the next block finishes.
module aes_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      data_in,
  input  logic [NK*32-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      data_out,
  output logic              busy
);

  localparam int CW  = $clog2(NR + 1);
  localparam int NW  = 4 * (NR + 1);
  localparam int NRK = 2 ** CW;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t               fsm_reg, fsm_next;
  logic [127:0]       state_reg;
  logic [NK*32-1:0]   key_reg;
  logic [CW-1:0]      round_reg;
  logic [127:0]       data_out_reg;
  logic [NW*32-1:0]   sched;
  logic [127:0]       rk [NRK];
  logic [127:0]       rk_cur;
  logic [127:0]       sr_state;
  logic [127:0]       mid_round;
  logic [127:0]       last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte (row r, column c) lives at index r + 4c, MSB-first.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [NW*32-1:0] expand_key(input logic [NK*32-1:0] k);
    logic [31:0]      w [NW];
    logic [31:0]      t;
    logic [7:0]       rc;
    logic [NW*32-1:0] o;
    rc = 8'h01;
    o  = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = k[NK*32-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NK] ^ t;
      end
      o[NW*32-1-32*i -: 32] = w[i];
    end
    return o;
  endfunction

  assign sched = expand_key(key_reg);

  // Round-key table padded to a power of two so the counter indexes it directly.
  for (genvar gi = 0; gi < NRK; gi++) begin : g_rk
    if (gi <= NR) begin : g_used
      assign rk[gi] = sched[NW*32-1-128*gi -: 128];
    end else begin : g_pad
      assign rk[gi] = '0;
    end
  end

  assign rk_cur     = rk[round_reg];
  assign sr_state   = shift_rows(sub_bytes(state_reg));
  assign mid_round  = mix_columns(sr_state) ^ rk_cur;
  assign last_round = sr_state ^ rk_cur;
  assign data_out   = data_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_reg <= IDLE;
    else        fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (round_reg == CW'(NR)) fsm_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Round key 0 is the first four key words, so it is taken straight from the input key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= '0;
      key_reg      <= '0;
      round_reg    <= '0;
      data_out_reg <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            key_reg   <= key;
            state_reg <= data_in ^ key[NK*32-1 -: 128];
            round_reg <= CW'(1);
          end
        end
        ROUND: begin
          if (round_reg == CW'(NR)) begin
            data_out_reg <= last_round;
          end else begin
            state_reg <= mid_round;
            round_reg <= round_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: three instances (NK=4/6/8) checked against known vectors
// and a GF(2^8)-arithmetic AES reference model.
module tb_aes_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in;
  logic [255:0] key_in;
  logic [127:0] data_out [3];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_cipher_iter #(.NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in), .key(key_in[255:128]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0]));

  aes_cipher_iter #(.NK(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in), .key(key_in[255:64]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1]));

  aes_cipher_iter #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in), .key(key_in), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2]));

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           corrupt;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (rnd < nr)
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            st[r+4*c] = gmul(8'h02, tmp[r+4*c]) ^ gmul(8'h03, tmp[(r+1)%4+4*c])
                      ^ tmp[(r+2)%4+4*c] ^ tmp[(r+3)%4+4*c];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_block(input int sel, input logic [127:0] pt, input logic [255:0] k,
                           input bit corrupt, input bit rnd_oready,
                           output logic [127:0] ct, output int lat);
    int guard;
    guard = 0;
    while (!in_ready[sel] && guard < 50) begin
      tick();
      guard++;
    end
    check("wait_in_ready", 128'(in_ready[sel]), 128'd1);
    data_in = pt; key_in = k; in_valid[sel] = 1'b1; out_ready[sel] = 1'b0;
    tick();
    if (corrupt) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end else begin
      in_valid[sel] = 1'b0;
    end
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      if (rnd_oready) out_ready[sel] = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    in_valid[sel] = 1'b0;
    ct = data_out[sel];
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    $display("block nk=%0d pt=%h ct=%h latency=%0d", 4 + 2 * sel, pt, ct, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [4];
    logic [127:0] ct, exp, pt, ct_q [2];
    logic [255:0] k;
    int           lat, sel, nk, n, t, t_q [2], seen;

    vecs[0] = '{nk: 4, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, corrupt: 1'b0};
    vecs[1] = '{nk: 4, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, corrupt: 1'b1};
    vecs[2] = '{nk: 6, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, corrupt: 1'b0};
    vecs[3] = '{nk: 8, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089, corrupt: 1'b0};

    rst_n = 1'b0; in_valid = '0; out_ready = '0; data_in = '0; key_in = '0;
    build_sbox();
    tick(); tick();
    check("reset_in_ready", 128'(in_ready), 128'h7);
    check("reset_out_valid", 128'(out_valid), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_data_out", data_out[0] | data_out[1] | data_out[2], 128'h0);
    rst_n = 1'b1;
    tick();

    // known-answer vectors
    for (int i = 0; i < 4; i++) begin
      sel = (vecs[i].nk - 4) / 2;
      run_block(sel, vecs[i].pt, vecs[i].key, vecs[i].corrupt, 1'b0, ct, lat);
      check($sformatf("kat%0d_ct", i), ct, vecs[i].ct);
      check($sformatf("kat%0d_latency", i), 128'(lat), 128'(vecs[i].nk + 6));
    end

    // randomized blocks against the reference model
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 2);
      nk  = 4 + 2 * sel;
      pt  = {$urandom, $urandom, $urandom, $urandom};
      k   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp = aes_ref(pt, k, nk);
      run_block(sel, pt, k, 1'($urandom_range(0, 1)), 1'b1, ct, lat);
      check($sformatf("rand%0d_ct", i), ct, exp);
      check($sformatf("rand%0d_latency", i), 128'(lat), 128'(nk + 6));
    end

    // backpressure in DONE on the NK=6 instance
    data_in = vecs[2].pt; key_in = vecs[2].key; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    t = 0;
    while (!out_valid[1] && t < 40) begin
      tick();
      t++;
    end
    check("bp_latency", 128'(t), 128'd12);
    in_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 128'(out_valid[1]), 128'd1);
      check("bp_in_ready", 128'(in_ready[1]), 128'd0);
      check("bp_data_out", data_out[1], vecs[2].ct);
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    check("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
    check("bp_release_out_valid", 128'(out_valid[1]), 128'd0);
    check("bp_data_out_retained", data_out[1], vecs[2].ct);
    $display("backpressure sequence done");

    // asynchronous reset in the middle of a block
    data_in = vecs[1].pt; key_in = vecs[1].key; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_mid_busy", 128'(busy[0]), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_mid_data_out", data_out[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    check("rst_no_stale_out_valid", 128'(seen), 128'd0);
    run_block(0, vecs[0].pt, vecs[0].key, 1'b0, 1'b0, ct, lat);
    check("rst_after_ct", ct, vecs[0].ct);
    $display("reset sequence done");

    // back-to-back blocks with in_valid and out_ready held high
    pt = {$urandom, $urandom, $urandom, $urandom};
    data_in = vecs[1].pt; key_in = vecs[1].key; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    tick();
    data_in = pt;
    n = 0; t = 0; t_q[0] = 0; t_q[1] = 0; ct_q[0] = '0; ct_q[1] = '0;
    while (n < 2 && t < 60) begin
      tick();
      t++;
      if (out_valid[0]) begin
        ct_q[n] = data_out[0];
        t_q[n]  = t;
        n++;
      end
    end
    in_valid[0] = 1'b0;
    tick();
    out_ready[0] = 1'b0;
    $display("back-to-back ct0=%h at %0d ct1=%h at %0d", ct_q[0], t_q[0], ct_q[1], t_q[1]);
    check("b2b_count", 128'(n), 128'd2);
    check("b2b_ct0", ct_q[0], vecs[1].ct);
    check("b2b_ct1", ct_q[1], aes_ref(pt, vecs[1].key, 4));
    check("b2b_first_latency", 128'(t_q[0]), 128'd10);
    check("b2b_spacing", 128'(t_q[1] - t_q[0]), 128'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
